// File: rtl/lanectrl_pause_pkg.sv
// Shared definitions for the lane-controller pause sequencer.
// Holds the sequencer state encoding, default timing constants and small
// constant-function helpers used for port widths and elaboration checks.
package lanectrl_pause_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ASSERT,
      ST_UPDATE,
      ST_HOLD,
      ST_RECOVER
   } state_e;

   localparam int DEF_NUM_REQ     = 4;
   localparam int DEF_PRE_CYCLES  = 3;
   localparam int DEF_POST_CYCLES = 2;
   localparam int DEF_GAP_CYCLES  = 2;
   localparam int DEF_CNT_W       = 4;

   // Ceiling log2; clog2(2)=1, clog2(4)=2, clog2(8)=3.
   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lanectrl_pause_rr_arb.sv
// Combinational round-robin pick.
// Ports:
//   req_i    : per-requester request levels
//   ptr_i    : index with highest priority this round
//   valid_o  : at least one request present
//   gnt_oh_o : one-hot winner
//   idx_o    : binary index of the winner
module lanectrl_pause_rr_arb
   import lanectrl_pause_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   localparam int IDX_W  = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic               valid_o,
   output logic [NUM_REQ-1:0] gnt_oh_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic [IDX_W:0] cand;

   // Walk offsets from farthest to nearest so the requester closest to the
   // pointer is the last (and therefore winning) assignment.
   always_comb begin
      valid_o  = 1'b0;
      gnt_oh_o = '0;
      idx_o    = '0;
      cand     = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         cand = {1'b0, ptr_i} + (IDX_W+1)'(off);
         if (cand >= (IDX_W+1)'(NUM_REQ)) begin
            cand = cand - (IDX_W+1)'(NUM_REQ);
         end
         if (req_i[cand[IDX_W-1:0]]) begin
            valid_o  = 1'b1;
            idx_o    = cand[IDX_W-1:0];
            gnt_oh_o = NUM_REQ'(1) << cand[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/lanectrl_pause_sequencer.sv
// Shares HS_IO_CLK_PAUSE between several requesters. A round-robin winner
// gets a pause window: PRE_CYCLES of pause, a one-cycle update strobe,
// POST_CYCLES of pause, then GAP_CYCLES of recovery with pause low.
// Ports:
//   clk_i             : system clock
//   reset_i           : synchronous active-high reset
//   req_i             : per-requester pause request (level)
//   gnt_o             : one-hot single-cycle update strobe
//   done_o            : one-hot single-cycle completion pulse
//   hs_io_clk_pause_o : registered pause to the lane controller
//   busy_o            : high whenever the sequencer is not idle
//   active_id_o       : index of the current owner, 0 when idle
module lanectrl_pause_sequencer
   import lanectrl_pause_pkg::*;
#(
   parameter int NUM_REQ     = DEF_NUM_REQ,
   parameter int PRE_CYCLES  = DEF_PRE_CYCLES,
   parameter int POST_CYCLES = DEF_POST_CYCLES,
   parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [NUM_REQ-1:0]         req_i,
   output logic [NUM_REQ-1:0]         gnt_o,
   output logic [NUM_REQ-1:0]         done_o,
   output logic                       hs_io_clk_pause_o,
   output logic                       busy_o,
   output logic [clog2(NUM_REQ)-1:0]  active_id_o
);

   localparam int IDX_W = clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("lanectrl_pause_sequencer: NUM_REQ must be 2..8");
   end
   if (PRE_CYCLES < 1 || POST_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_timing
      $error("lanectrl_pause_sequencer: PRE/POST/GAP cycles must be >= 1");
   end
   if ((1 << CNT_W) <= max3(PRE_CYCLES, POST_CYCLES, GAP_CYCLES)) begin : g_bad_cnt_w
      $error("lanectrl_pause_sequencer: CNT_W too small for timing constants");
   end

   // Counters load length-1 and the phase ends when they reach zero.
   localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_CYCLES - 1);
   localparam logic [CNT_W-1:0] POST_LOAD = CNT_W'(POST_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [IDX_W-1:0]    ptr_q;
   logic [IDX_W-1:0]    id_q;
   logic                pause_q;
   logic                busy_q;
   logic [NUM_REQ-1:0]  gnt_q;
   logic [NUM_REQ-1:0]  done_q;

   logic                arb_valid;
   logic [NUM_REQ-1:0]  arb_oh;
   logic [IDX_W-1:0]    arb_idx;
   logic [IDX_W:0]      ptr_wrap;
   logic [IDX_W-1:0]    ptr_d;

   lanectrl_pause_rr_arb #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req_i    (req_i),
      .ptr_i    (ptr_q),
      .valid_o  (arb_valid),
      .gnt_oh_o (arb_oh),
      .idx_o    (arb_idx)
   );

   // Next search start is one past the winner, wrapping at NUM_REQ.
   always_comb begin
      ptr_wrap = {1'b0, arb_idx} + (IDX_W+1)'(1);
      ptr_d    = (ptr_wrap == (IDX_W+1)'(NUM_REQ)) ? '0 : ptr_wrap[IDX_W-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         id_q    <= '0;
         pause_q <= 1'b0;
         busy_q  <= 1'b0;
         gnt_q   <= '0;
         done_q  <= '0;
      end else begin
         gnt_q  <= '0;
         done_q <= '0;
         unique case (state_q)
            // The last recovery cycle doubles as an arbitration point, so a
            // waiting requester sees pause low for exactly GAP_CYCLES.
            ST_IDLE, ST_RECOVER: begin
               if (state_q == ST_RECOVER && cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_ONE;
               end else if (arb_valid) begin
                  state_q <= ST_ASSERT;
                  cnt_q   <= PRE_LOAD;
                  id_q    <= arb_idx;
                  ptr_q   <= ptr_d;
                  pause_q <= 1'b1;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  id_q    <= '0;
                  busy_q  <= 1'b0;
               end
            end
            ST_ASSERT: begin
               if (cnt_q == '0) begin
                  state_q <= ST_UPDATE;
                  gnt_q   <= NUM_REQ'(1) << id_q;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            ST_UPDATE: begin
               state_q <= ST_HOLD;
               cnt_q   <= POST_LOAD;
            end
            ST_HOLD: begin
               if (cnt_q == '0) begin
                  state_q <= ST_RECOVER;
                  cnt_q   <= GAP_LOAD;
                  pause_q <= 1'b0;
                  done_q  <= NUM_REQ'(1) << id_q;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               pause_q <= 1'b0;
            end
         endcase
      end
   end

   assign gnt_o             = gnt_q;
   assign done_o            = done_q;
   assign hs_io_clk_pause_o = pause_q;
   assign busy_o            = busy_q;
   assign active_id_o       = id_q;

endmodule
